// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter that lets N packet requesters share one UART transmit FIFO.
//   A requester holds the grant for a whole packet. The grant is released on the
//   byte marked last, on a forced release after max_len bytes, or on an abort after
//   the granted requester has stalled for timeout cycles. The search for the next
//   winner starts just above the requester that was granted most recently.
//
// Ports
//   clk       : clock, all state updates on the rising edge
//   reset     : asynchronous active-low reset
//   req       : per-requester byte valid / packet in progress
//   data      : requester i byte at data[i*dbits +: dbits]
//   last      : per-requester last-byte marker, qualified by req
//   ack       : one-hot byte-accepted strobe (combinational)
//   tx_full   : UART transmit FIFO full flag
//   wr_uart   : UART FIFO write strobe (combinational)
//   wr_data   : byte to the UART FIFO (combinational mux of the granted requester)
//   busy      : high while a grant is held
//   grant_id  : index of the current or most recent grant
//   err       : one-cycle pulse after a timeout abort or a max_len forced release
module uart_tx_arbiter #(
  parameter int N       = 4,
  parameter int dbits   = 8,
  parameter int max_len = 16,
  parameter int timeout = 255,
  localparam int GW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       req,
  input  logic [N*dbits-1:0] data,
  input  logic [N-1:0]       last,
  output logic [N-1:0]       ack,
  input  logic               tx_full,
  output logic               wr_uart,
  output logic [dbits-1:0]   wr_data,
  output logic               busy,
  output logic [GW-1:0]      grant_id,
  output logic               err
);

  localparam int CW = $clog2(max_len + 1);
  localparam int SW = GW + 1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    stall_q, stall_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;

  logic          accept_s;
  logic          found_s;
  logic [GW-1:0] winner_s;
  logic [GW-1:0] next_ptr_s;
  logic [SW-1:0] cand_s;

  // Round-robin search: first set req bit at or above ptr, wrapping past N-1.
  always_comb begin
    winner_s = '0;
    found_s  = 1'b0;
    cand_s   = '0;
    for (int k = 0; k < N; k++) begin
      cand_s = {1'b0, ptr_q} + SW'(k);
      if (cand_s >= SW'(N)) begin
        cand_s = cand_s - SW'(N);
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && req[cand_s[GW-1:0]]) begin
        found_s  = 1'b1;
        winner_s = cand_s[GW-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

  // Pointer value used after any release: one above the requester just served.
  always_comb begin
    if (grant_q == GW'(N - 1)) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = grant_q + GW'(1);
    end
  end

  // Byte-accept strobe, one-hot ack and data mux toward the UART FIFO.
  always_comb begin
    accept_s = 1'b0;
    ack      = '0;
    wr_data  = '0;
    if (state_q == S_SEND) begin
      accept_s = req[grant_q] && !tx_full;
      for (int i = 0; i < N; i++) begin
        if (grant_q == GW'(i)) begin
          ack[i]  = accept_s;
          wr_data = data[i*dbits +: dbits];
        end else begin
          ack[i] = 1'b0;
        end
      end
    end else begin
      accept_s = 1'b0;
    end
  end

  assign wr_uart = accept_s;

  // Next-state logic for the grant, pointer, byte counter and stall counter.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    stall_d = stall_q;
    busy_d  = busy_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // The grant is only decided here, so the first byte is accepted a cycle later.
        if (found_s) begin
          state_d = S_SEND;
          grant_d = winner_s;
          busy_d  = 1'b1;
          cnt_d   = '0;
          stall_d = '0;
        end else begin
          busy_d = 1'b0;
        end
      end
      S_SEND: begin
        if (accept_s) begin
          stall_d = '0;
          // The max_len-th byte closes the packet even without last, and flags it.
          if (last[grant_q] || (cnt_q == CW'(max_len - 1))) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            ptr_d   = next_ptr_s;
            cnt_d   = '0;
            err_d   = !last[grant_q];
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (!req[grant_q]) begin
          // Requester went quiet: count it, abort once the count reaches timeout.
          if (stall_q == 8'(timeout - 1)) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            ptr_d   = next_ptr_s;
            cnt_d   = '0;
            stall_d = '0;
            err_d   = 1'b1;
          end else begin
            stall_d = stall_q + 8'd1;
          end
        end else begin
          // FIFO backpressure is not the requester's fault: stall count holds.
          stall_d = stall_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset returns to IDLE with the pointer at requester 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      stall_q <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign busy     = busy_q;
  assign grant_id = grant_q;
  assign err      = err_q;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N, default 4: number of requesters sharing the UART transmit path.
REQ-002 Parameter dbits, default 8: byte width on every data port.
REQ-003 Parameter max_len, default 16: maximum bytes per packet before forced release.
REQ-004 Parameter timeout, default 255: stall cycles tolerated from the granted requester (range 1..255).
REQ-005 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-006 Port reset, input, 1: asynchronous, active-low reset.
REQ-007 Port req, input, N: per-requester "byte valid / packet in progress".
REQ-008 Port data, input, N*dbits: requester i byte at bits [i*dbits +: dbits].
REQ-009 Port last, input, N: marks the final byte of a packet; qualified by req.
REQ-010 Port ack, output, N: one-hot byte-accepted strobe, combinational.
REQ-011 Port tx_full, input, 1: full flag from the UART transmit FIFO.
REQ-012 Port wr_uart, output, 1: write strobe to the UART transmit FIFO, combinational.
REQ-013 Port wr_data, output, dbits: byte to the UART transmit FIFO, combinational mux.
REQ-014 Port busy, output, 1: high while a grant is held.
REQ-015 Port grant_id, output, clog2(N): index of the current or most recent grant.
REQ-016 Port err, output, 1: one-cycle pulse on a timeout abort or a max_len forced release.

Function
REQ-017 State machine: IDLE and SEND; registered state, grant_id, rr pointer, byte counter, stall counter.
REQ-018 IDLE with any req bit set: grant the first set bit searching from ptr upward with wrap; next cycle state=SEND, busy=1, grant_id=winner.
REQ-019 IDLE: ack=0 and wr_uart=0; no byte is ever accepted in the grant cycle; latency from req to first accept is 1 cycle minimum.
REQ-020 SEND: accept = req[grant_id] && !tx_full; ack[grant_id]=accept, wr_uart=accept, wr_data=data[grant_id]; ack for all other requesters = 0.
REQ-021 tx_full=1 blocks accept with no data loss; requester holds data until ack.
REQ-022 Accept with last=1: next state IDLE, ptr=grant_id+1 mod N, byte counter cleared.
REQ-023 Byte counter increments per accept; the max_len-th accept without last is treated as last, with err=1 on the following cycle.
REQ-024 Stall counter increments on SEND cycles with req[grant_id]=0; it holds during tx_full stalls and clears on any accept.
REQ-025 Stall counter reaching timeout: abort to IDLE, err=1 on the next cycle, ptr advances as for REQ-022, and no ack is issued.
REQ-026 Requests from non-granted requesters are ignored until return to IDLE; no preemption.
REQ-027 Fairness: requester i, when continuously requesting, is granted within N-1 packets of other requesters.
REQ-028 When release and a new request coincide, the new grant is decided in the IDLE cycle, giving one idle cycle between packets.

Reset
REQ-029 reset=0 asynchronously forces: state=IDLE, busy=0, grant_id=0, ptr=0, counters=0, err=0, ack=0, wr_uart=0.
REQ-030 Reset asserted mid-packet abandons the packet silently; the first post-reset grant goes to the lowest-index active requester.

Verification
REQ-031 Single packet: req0 with 3 bytes 0x41,0x42,0x43 (last on 0x43), tx_full=0 -> grant on cycle 1, wr_uart high cycles 1-3 with those bytes, busy falls cycle 4.
REQ-032 Round robin: req0..req3 all requesting 1-byte packets continuously -> grant order 0,1,2,3,0 with one idle cycle between packets.
REQ-033 Backpressure: tx_full=1 for 5 cycles mid-packet -> ack=0 and wr_uart=0 throughout, no byte lost or duplicated, and the stall counter does not advance.
REQ-034 Timeout: timeout=4, granted req2 drops req after 1 byte -> err pulse 5 cycles later, busy=0, next grant to requester 3 if it is requesting.
REQ-035 Max length: max_len=4, req1 streams 6 bytes without last -> 4 accepted, err pulse, grant passes on, and req1's remaining bytes are re-arbitrated as a new packet.
REQ-036 Reset mid-packet: reset low during byte 2 of requester 3 -> all outputs zero immediately; after release, req0 and req3 both active -> requester 0 granted.
